// File: rtl/nor_quad_arbiter.sv
// Round-robin arbiter giving four requesters time-shared access to one
// external quad 2-input NOR gate. The winner's operand slices drive the gate
// for HOLD_CYCLES cycles. The gate output is then captured into Y_OUT, and the
// winner receives a one-cycle ACK.
module nor_quad_arbiter #(
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  REQ,
   input  logic [15:0] REQ_A,
   input  logic [15:0] REQ_B,
   output logic [3:0]  GNT,
   output logic [3:0]  ACK,
   output logic [3:0]  Y_OUT,
   output logic [3:0]  G_A,
   output logic [3:0]  G_B,
   input  logic [3:0]  G_Y,
   output logic        BUSY
);

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned LANE_W = 4;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt,  w_cnt_nxt;
   logic [IDX_W-1:0]    r_ptr,  w_ptr_nxt;
   logic [IDX_W-1:0]    r_idx,  w_idx_nxt;
   logic [N_REQ-1:0]    r_gnt,  w_gnt_nxt;
   logic [N_REQ-1:0]    r_ack,  w_ack_nxt;
   logic [LANE_W-1:0]   r_y,    w_y_nxt;
   logic [LANE_W-1:0]   r_ga,   w_ga_nxt;
   logic [LANE_W-1:0]   r_gb,   w_gb_nxt;
   logic                r_busy, w_busy_nxt;
   logic                w_found;
   logic [IDX_W-1:0]    w_pick;
   logic [IDX_W-1:0]    w_cand;

   // First active request at or above the pointer, wrapping 3 -> 0
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_ptr;
      w_cand  = r_ptr;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_cand = IDX_W'(r_ptr + IDX_W'(k));
         if (!w_found && REQ[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_found) w_state_nxt = ST_DRIVE;
         ST_DRIVE: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_ptr_nxt = r_ptr;
      w_idx_nxt = r_idx;
      w_gnt_nxt = r_gnt;
      w_ack_nxt = '0;
      w_y_nxt   = r_y;
      w_ga_nxt  = r_ga;
      w_gb_nxt  = r_gb;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_idx_nxt = w_pick;
               w_gnt_nxt = N_REQ'(1) << w_pick;
               w_ga_nxt  = REQ_A[{w_pick, 2'b00} +: LANE_W];
               w_gb_nxt  = REQ_B[{w_pick, 2'b00} +: LANE_W];
               w_cnt_nxt = CNT_W'(HOLD_CYCLES);
            end
         end
         ST_DRIVE: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_y_nxt   = G_Y;
               w_ack_nxt = N_REQ'(1) << r_idx;
            end
         end
         ST_DONE: begin
            w_gnt_nxt = '0;
            w_ptr_nxt = IDX_W'(r_idx + IDX_W'(1));
         end
         default: begin
            w_gnt_nxt = '0;
         end
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // Datapath and output registers; reset aborts any transaction
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt  <= '0;
         r_ptr  <= '0;
         r_idx  <= '0;
         r_gnt  <= '0;
         r_ack  <= '0;
         r_y    <= '0;
         r_ga   <= '0;
         r_gb   <= '0;
         r_busy <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_ptr  <= w_ptr_nxt;
         r_idx  <= w_idx_nxt;
         r_gnt  <= w_gnt_nxt;
         r_ack  <= w_ack_nxt;
         r_y    <= w_y_nxt;
         r_ga   <= w_ga_nxt;
         r_gb   <= w_gb_nxt;
         r_busy <= w_busy_nxt;
      end
   end

   assign GNT   = r_gnt;
   assign ACK   = r_ack;
   assign Y_OUT = r_y;
   assign G_A   = r_ga;
   assign G_B   = r_gb;
   assign BUSY  = r_busy;

endmodule
